// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time on a valid/ready handshake.
// The response appears after a fixed wait-state count. A side port loads the program image.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        FetchReq,
  input  logic [15:0] FetchAddr,
  output logic        FetchReady,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [15:0] RespInstr,
  output logic        RespErr,
  input  logic        LoadEn,
  input  logic [15:0] LoadAddr,
  input  logic [15:0] LoadData
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [15:0] mem_q [DEPTH_WORDS];

  logic [15:0] fa_s;
  logic        fetch_err_s;
  logic        load_ok_s;
  logic        enter_resp_s;

  assign FetchReady = (state_q == S_IDLE) && Reset_n;
  assign RespValid  = (state_q == S_RESP);
  assign RespInstr  = instr_q;
  assign RespErr    = err_q;

  // In IDLE (the zero-wait case) the word is read from the live request address.
  assign fa_s        = (state_q == S_IDLE) ? FetchAddr : addr_q;
  assign fetch_err_s = fa_s[0] || ({2'b00, fa_s[15:1]} >= DEPTH_L);
  assign load_ok_s   = LoadEn && !LoadAddr[0] && ({2'b00, LoadAddr[15:1]} < DEPTH_L);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      instr_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (load_ok_s) begin
      mem_q[LoadAddr[AW:1]] <= LoadData;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (FetchReq) begin
          addr_d = FetchAddr;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (RespReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture on RESP entry only; a same-edge load to the fetched word wins (write-first).
  always_comb begin
    instr_d      = instr_q;
    err_d        = err_q;
    enter_resp_s = (state_d == S_RESP) && (state_q != S_RESP);
    if (enter_resp_s) begin
      if (fetch_err_s) begin
        instr_d = NOP_INSTR;
        err_d   = 1'b1;
      end else if (load_ok_s && (LoadAddr[15:1] == fa_s[15:1])) begin
        instr_d = LoadData;
        err_d   = 1'b0;
      end else begin
        instr_d = mem_q[fa_s[AW:1]];
        err_d   = 1'b0;
      end
    end else begin
      instr_d = instr_q;
      err_d   = err_q;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a one-wait-state instance drives the vector table and corner sequences.
// A zero-wait instance checks back-to-back throughput.
module tb_imem_responder;

  logic        Clock;
  logic        Reset_n;
  logic        LoadEn;
  logic [15:0] LoadAddr, LoadData;

  logic        FetchReq1, FetchReady1, RespValid1, RespReady1, RespErr1;
  logic [15:0] FetchAddr1, RespInstr1;
  logic        FetchReq0, FetchReady0, RespValid0, RespReady0, RespErr0;
  logic [15:0] FetchAddr0, RespInstr0;

  int n_checks = 0;
  int n_fail   = 0;

  imem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .NOP_INSTR(16'h0000)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n),
    .FetchReq(FetchReq1), .FetchAddr(FetchAddr1), .FetchReady(FetchReady1),
    .RespValid(RespValid1), .RespReady(RespReady1), .RespInstr(RespInstr1), .RespErr(RespErr1),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData)
  );

  imem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .NOP_INSTR(16'h0000)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n),
    .FetchReq(FetchReq0), .FetchAddr(FetchAddr0), .FetchReady(FetchReady0),
    .RespValid(RespValid0), .RespReady(RespReady0), .RespInstr(RespInstr0), .RespErr(RespErr0),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    @(negedge Clock);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    @(posedge Clock);
    @(negedge Clock);
    LoadEn = 1'b0;
  endtask

  // Full one-wait-state transaction: accept, one WAIT cycle, response, handshake.
  task automatic fetch1(input logic [15:0] a, input logic [15:0] exp_i, input logic exp_e);
    @(negedge Clock);
    FetchReq1 = 1'b1; FetchAddr1 = a;
    chk("ready_before_accept", FetchReady1, 1'b1);
    @(posedge Clock);
    @(negedge Clock);
    FetchReq1 = 1'b0;
    chk("valid_low_in_wait", RespValid1, 1'b0);
    @(posedge Clock);
    @(negedge Clock);
    chk("valid_after_wait", RespValid1, 1'b1);
    chk("resp_instr", RespInstr1, exp_i);
    chk("resp_err", RespErr1, exp_e);
    RespReady1 = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    RespReady1 = 1'b0;
    chk("valid_drop_after_hs", RespValid1, 1'b0);
    chk("ready_after_hs", FetchReady1, 1'b1);
  endtask

  initial begin
    logic [15:0] seq_addr [3];
    logic [15:0] seq_data [3];

    vecs[0] = '{addr: 16'h0002, instr: 16'hABCD, err: 1'b0};
    vecs[1] = '{addr: 16'h0000, instr: 16'h1234, err: 1'b0};
    vecs[2] = '{addr: 16'h0004, instr: 16'h1111, err: 1'b0};
    vecs[3] = '{addr: 16'h01FE, instr: 16'h7777, err: 1'b0};
    vecs[4] = '{addr: 16'h0003, instr: 16'h0000, err: 1'b1};
    vecs[5] = '{addr: 16'h0200, instr: 16'h0000, err: 1'b1};
    vecs[6] = '{addr: 16'hFFFE, instr: 16'h0000, err: 1'b1};
    vecs[7] = '{addr: 16'h0001, instr: 16'h0000, err: 1'b1};
    seq_addr[0] = 16'h0000; seq_data[0] = 16'h1234;
    seq_addr[1] = 16'h0002; seq_data[1] = 16'hABCD;
    seq_addr[2] = 16'h0004; seq_data[2] = 16'h1111;

    Reset_n = 1'b0; LoadEn = 1'b0; LoadAddr = 16'h0000; LoadData = 16'h0000;
    FetchReq1 = 1'b0; FetchAddr1 = 16'h0000; RespReady1 = 1'b0;
    FetchReq0 = 1'b0; FetchAddr0 = 16'h0000; RespReady0 = 1'b0;

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_valid", RespValid1, 1'b0);
    chk("rst_instr", RespInstr1, 16'h0000);
    chk("rst_err", RespErr1, 1'b0);
    chk("rst_ready_low", FetchReady1, 1'b0);
    chk("rst_valid0", RespValid0, 1'b0);
    Reset_n = 1'b1;
    #1;
    chk("ready_after_rst", FetchReady1, 1'b1);
    chk("ready_after_rst0", FetchReady0, 1'b1);

    // Program image, plus a misaligned and an out-of-range load that must be dropped.
    load(16'h0000, 16'h1234);
    load(16'h0002, 16'hABCD);
    load(16'h0004, 16'h1111);
    load(16'h01FE, 16'h7777);
    load(16'h0003, 16'hDEAD);
    load(16'h0200, 16'hBEEF);

    for (int i = 0; i < 8; i++) begin
      fetch1(vecs[i].addr, vecs[i].instr, vecs[i].err);
    end

    // Zero wait states, RespReady tied high: a response every second cycle.
    RespReady0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      FetchReq0 = 1'b1; FetchAddr0 = seq_addr[k];
      chk("b2b_ready", FetchReady0, 1'b1);
      @(posedge Clock);
      @(negedge Clock);
      chk("b2b_valid", RespValid0, 1'b1);
      chk("b2b_instr", RespInstr0, seq_data[k]);
      chk("b2b_ready_busy", FetchReady0, 1'b0);
      @(posedge Clock);
    end
    @(negedge Clock);
    FetchReq0 = 1'b0;
    chk("b2b_idle", RespValid0, 1'b0);

    // Hold the response for 5 cycles while a load rewrites the fetched word.
    @(negedge Clock);
    FetchReq1 = 1'b1; FetchAddr1 = 16'h0000;
    @(posedge Clock);
    @(negedge Clock);
    FetchReq1 = 1'b0;
    @(posedge Clock);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      LoadEn = (c == 1);
      LoadAddr = 16'h0000; LoadData = 16'h9999;
      chk("hold_valid", RespValid1, 1'b1);
      chk("hold_instr", RespInstr1, 16'h1234);
      chk("hold_ready_low", FetchReady1, 1'b0);
      @(posedge Clock);
    end
    @(negedge Clock);
    LoadEn = 1'b0;
    RespReady1 = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    RespReady1 = 1'b0;
    chk("hold_release_valid", RespValid1, 1'b0);
    chk("hold_release_ready", FetchReady1, 1'b1);
    fetch1(16'h0000, 16'h9999, 1'b0);

    // Reset during WAIT discards the transaction.
    @(negedge Clock);
    FetchReq1 = 1'b1; FetchAddr1 = 16'h0002;
    @(posedge Clock);
    @(negedge Clock);
    FetchReq1 = 1'b0;
    Reset_n = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("rst_wait_valid", RespValid1, 1'b0);
    chk("rst_wait_ready_low", FetchReady1, 1'b0);
    Reset_n = 1'b1;
    #1;
    chk("rst_wait_ready", FetchReady1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      chk("rst_wait_no_resp", RespValid1, 1'b0);
    end

    // Load to the in-flight word on the RESP-entry edge is returned (write-first).
    @(negedge Clock);
    FetchReq1 = 1'b1; FetchAddr1 = 16'h0004;
    @(posedge Clock);
    @(negedge Clock);
    FetchReq1 = 1'b0;
    LoadEn = 1'b1; LoadAddr = 16'h0004; LoadData = 16'h5555;
    @(posedge Clock);
    @(negedge Clock);
    LoadEn = 1'b0;
    chk("wf_valid", RespValid1, 1'b1);
    chk("wf_instr", RespInstr1, 16'h5555);
    chk("wf_err", RespErr1, 1'b0);
    RespReady1 = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    RespReady1 = 1'b0;
    chk("wf_done", RespValid1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
